// File: rtl/tree_result_acc.sv
// Aligns a valid flag with the adder tree's fixed latency and accumulates a programmed
// number of tree results into one wide total. Define TREE_RESULT_ACC_SAT_EN to saturate on overflow.
module tree_result_acc #(
    parameter int ACC_BW   = 32,
    parameter int OUT_BW   = 40,
    parameter int TREE_LAT = 3,
    parameter int LEN_BW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_BW-1:0] cfg_len,
    output logic              busy,
    input  logic              in_valid,
    input  logic [ACC_BW-1:0] tree_sum,
    output logic [OUT_BW-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [TREE_LAT-1:0] v_pipe;
    logic                v_al;
    logic [OUT_BW-1:0]   acc;
    logic [OUT_BW-1:0]   acc_next;
    logic [OUT_BW:0]     sum_ext;
    logic                carry;
    logic [LEN_BW-1:0]   cnt;
    logic [LEN_BW-1:0]   len;
    logic                last;
    logic                take_start;

    assign v_al = v_pipe[TREE_LAT-1];
    assign last = (cnt == len - LEN_BW'(1));

    // A start is honoured from IDLE, or from DONE when the result is handed off that cycle.
    assign take_start = start && (cfg_len != '0) &&
                        ((state == IDLE) || ((state == DONE) && out_ready));

    // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
    always_comb begin
        sum_ext = {1'b0, acc} + {{(OUT_BW + 1 - ACC_BW){1'b0}}, tree_sum};
        carry   = sum_ext[OUT_BW];
`ifdef TREE_RESULT_ACC_SAT_EN
        acc_next = carry ? {OUT_BW{1'b1}} : sum_ext[OUT_BW-1:0];
`else
        acc_next = sum_ext[OUT_BW-1:0];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe    <= '0;
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            v_pipe[0] <= in_valid;
            for (int i = 1; i < TREE_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
            end

            if (take_start) begin
                state     <= ACC;
                len       <= cfg_len;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
                overrun   <= v_al;
                out_valid <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (v_al) overrun <= 1'b1;
                    end
                    ACC: begin
                        if (v_al) begin
                            acc <= acc_next;
                            cnt <= cnt + LEN_BW'(1);
                            if (carry) ovf <= 1'b1;
                            if (last) begin
                                state     <= DONE;
                                out_data  <= acc_next;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (v_al) overrun <= 1'b1;
                        if (out_ready) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tree_result_acc.sv
// Directed bench for tree_result_acc: a default-width instance plus an 8-bit instance for overflow.
module tb_tree_result_acc;

    localparam int TL = 3;

`ifdef TREE_RESULT_ACC_SAT_EN
    localparam logic [7:0] OVF_EXP = 8'd255;
`else
    localparam logic [7:0] OVF_EXP = 8'd44;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;
    logic [15:0] cfg_len_a, cfg_len_b;
    logic        vld_a, vld_b;
    logic        out_ready_a, out_ready_b;
    logic [31:0] vec_sum;
    logic [31:0] sum_pipe [TL];
    logic [31:0] tree_sum;

    logic        busy_a, out_valid_a, overrun_a, ovf_a;
    logic [39:0] out_data_a;
    logic        busy_b, out_valid_b, overrun_b, ovf_b;
    logic [7:0]  out_data_b;

    int passed = 0;
    int total  = 0;

    // Stand-in for the adder tree: the sum presented with a vector emerges TL edges later.
    always @(posedge clk) begin
        sum_pipe[0] <= vec_sum;
        for (int i = 1; i < TL; i++) sum_pipe[i] <= sum_pipe[i-1];
    end
    assign tree_sum = sum_pipe[TL-1];

    tree_result_acc #(.ACC_BW(32), .OUT_BW(40), .TREE_LAT(TL), .LEN_BW(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cfg_len(cfg_len_a), .busy(busy_a),
        .in_valid(vld_a), .tree_sum(tree_sum), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .overrun(overrun_a), .ovf(ovf_a)
    );

    tree_result_acc #(.ACC_BW(8), .OUT_BW(8), .TREE_LAT(TL), .LEN_BW(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cfg_len(cfg_len_b), .busy(busy_b),
        .in_valid(vld_b), .tree_sum(tree_sum[7:0]), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .overrun(overrun_b), .ovf(ovf_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        steps(2);
        total++; if ({busy_a, out_valid_a, overrun_a, ovf_a} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {busy_a, out_valid_a, overrun_a, ovf_a}); else passed++;
        total++; if (out_data_a !== 40'd0) $display("FAIL reset_data: got %0d expected 0", out_data_a); else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        cfg_len_a = 16'd4; start_a = 1'b1;
        step();
        start_a = 1'b0;
        total++; if (busy_a !== 1'b1) $display("FAIL basic_busy_start: got %b expected 1", busy_a); else passed++;
        vld_a = 1'b1;
        vec_sum = 32'd10; step();
        vec_sum = 32'd20; step();
        vec_sum = 32'd30; step();
        vec_sum = 32'd40; step();
        vld_a = 1'b0; vec_sum = 32'd0;
        steps(TL - 1);
        total++; if (out_valid_a !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", out_valid_a); else passed++;
        total++; if (busy_a !== 1'b1) $display("FAIL basic_busy_acc: got %b expected 1", busy_a); else passed++;
        step();
        total++; if (out_valid_a !== 1'b1) $display("FAIL basic_valid: got %b expected 1", out_valid_a); else passed++;
        total++; if (out_data_a !== 40'd100) $display("FAIL basic_data: got %0d expected 100", out_data_a); else passed++;
        total++; if (ovf_a !== 1'b0) $display("FAIL basic_ovf: got %b expected 0", ovf_a); else passed++;
    endtask

    task automatic test_backpressure();
        out_ready_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (out_valid_a !== 1'b1 || out_data_a !== 40'd100 || busy_a !== 1'b1)
                $display("FAIL hold_%0d: got valid=%b data=%0d busy=%b expected 1/100/1", i, out_valid_a, out_data_a, busy_a);
            else passed++;
        end
        out_ready_a = 1'b1;
        step();
        out_ready_a = 1'b0;
        total++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL handshake: got valid=%b busy=%b expected 0/0", out_valid_a, busy_a); else passed++;
    endtask

    task automatic test_zero_len();
        cfg_len_a = 16'd0; start_a = 1'b1;
        step();
        start_a = 1'b0;
        total++; if (busy_a !== 1'b0) $display("FAIL zero_len_busy: got %b expected 0", busy_a); else passed++;
        step();
        total++; if (busy_a !== 1'b0 || out_valid_a !== 1'b0) $display("FAIL zero_len_idle: got busy=%b valid=%b expected 0/0", busy_a, out_valid_a); else passed++;
    endtask

    task automatic test_gapped_overrun();
        cfg_len_a = 16'd3; start_a = 1'b1;
        step();
        start_a = 1'b0;
        vld_a = 1'b1; vec_sum = 32'd1; step();
        vld_a = 1'b0; vec_sum = 32'd0; step();
        vld_a = 1'b1; vec_sum = 32'd2; step();
        vld_a = 1'b0; vec_sum = 32'd0; steps(4);
        vld_a = 1'b1; vec_sum = 32'd3; step();
        vld_a = 1'b0; vec_sum = 32'd0;
        steps(TL);
        total++; if (out_valid_a !== 1'b1 || out_data_a !== 40'd6) $display("FAIL gapped_data: got valid=%b data=%0d expected 1/6", out_valid_a, out_data_a); else passed++;
        total++; if (overrun_a !== 1'b0) $display("FAIL gapped_overrun: got %b expected 0", overrun_a); else passed++;
        vld_a = 1'b1; vec_sum = 32'd99; step();
        vld_a = 1'b0; vec_sum = 32'd0;
        steps(TL);
        total++; if (overrun_a !== 1'b1) $display("FAIL done_overrun: got %b expected 1", overrun_a); else passed++;
        total++; if (out_data_a !== 40'd6 || out_valid_a !== 1'b1) $display("FAIL done_hold: got valid=%b data=%0d expected 1/6", out_valid_a, out_data_a); else passed++;
    endtask

    task automatic test_back_to_back();
        out_ready_a = 1'b1; start_a = 1'b1; cfg_len_a = 16'd2;
        vld_a = 1'b1; vec_sum = 32'd5;
        step();
        out_ready_a = 1'b0; start_a = 1'b0;
        total++; if (busy_a !== 1'b1 || out_valid_a !== 1'b0 || overrun_a !== 1'b0)
            $display("FAIL b2b_enter: got busy=%b valid=%b overrun=%b expected 1/0/0", busy_a, out_valid_a, overrun_a);
        else passed++;
        vec_sum = 32'd7; step();
        vld_a = 1'b0; vec_sum = 32'd0;
        steps(TL);
        total++; if (out_valid_a !== 1'b1 || out_data_a !== 40'd12) $display("FAIL b2b_data: got valid=%b data=%0d expected 1/12", out_valid_a, out_data_a); else passed++;
        total++; if (overrun_a !== 1'b0) $display("FAIL b2b_overrun: got %b expected 0", overrun_a); else passed++;
        out_ready_a = 1'b1; step(); out_ready_a = 1'b0;
    endtask

    task automatic test_overflow();
        cfg_len_b = 16'd2; start_b = 1'b1;
        step();
        start_b = 1'b0;
        vld_b = 1'b1; vec_sum = 32'd200; step();
        vec_sum = 32'd100; step();
        vld_b = 1'b0; vec_sum = 32'd0;
        steps(TL);
        total++; if (out_valid_b !== 1'b1 || out_data_b !== OVF_EXP) $display("FAIL ovf_data: got valid=%b data=%0d expected 1/%0d", out_valid_b, out_data_b, OVF_EXP); else passed++;
        total++; if (ovf_b !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", ovf_b); else passed++;
        out_ready_b = 1'b1; step(); out_ready_b = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        cfg_len_a = 16'd4; start_a = 1'b1;
        step();
        start_a = 1'b0;
        vld_a = 1'b1; vec_sum = 32'd3; steps(2);
        vld_a = 1'b0; vec_sum = 32'd0;
        rst = 1'b1;
        step();
        total++; if ({busy_a, out_valid_a, overrun_a, ovf_a} !== 4'b0000 || out_data_a !== 40'd0)
            $display("FAIL midrst_outputs: got flags=%b data=%0d expected 0000/0", {busy_a, out_valid_a, overrun_a, ovf_a}, out_data_a);
        else passed++;
        total++; if (ovf_b !== 1'b0 || out_data_b !== 8'd0) $display("FAIL midrst_b: got ovf=%b data=%0d expected 0/0", ovf_b, out_data_b); else passed++;
        rst = 1'b0;
        steps(TL + 1);
        total++; if (overrun_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL midrst_pipe: got overrun=%b busy=%b expected 0/0", overrun_a, busy_a); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        cfg_len_a = '0; cfg_len_b = '0;
        vld_a = 1'b0; vld_b = 1'b0;
        out_ready_a = 1'b0; out_ready_b = 1'b0;
        vec_sum = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_gapped_overrun();
        test_back_to_back();
        test_overflow();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
